// File: rtl/eth_payload_port.sv
// eth_payload_port
//   Byte-wide bridge between a MAC and a simple register-style payload port.
//   RX: MAC bytes land in a show-ahead FIFO that software drains with i_rreq.
//   TX: software writes bytes one at a time. A frame closes after GAP_CYCLES idle
//       cycles, or when TX_MAX bytes are stored. It is then streamed to the MAC
//       with a valid/ready handshake.
//
// Optional feature macro: ETH_PORT_TX_PAD_EN
//   When defined, frames shorter than MIN_LEN are padded with 8'h00 up to
//   MIN_LEN bytes.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_mac_rx_data/valid/last  RX byte stream from MAC
//   o_rdata, o_rready, i_rreq FIFO head byte, not-empty flag, pop request
//   i_wdata, i_wvalid         TX byte write
//   o_wready                  TX write is accepted when high
//   o_mac_tx_data/valid/last  TX frame stream to MAC
//   i_mac_tx_ready            TX stream ready from MAC
//   o_rx_ovf                  sticky RX overflow flag
module eth_payload_port #(
  parameter int RX_AW      = 10,
  parameter int TX_MAX     = 1500,
  parameter int GAP_CYCLES = 62,
  parameter int MIN_LEN    = 46
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_mac_rx_data,
  input  logic       i_mac_rx_valid,
  input  logic       i_mac_rx_last,
  output logic [7:0] o_rdata,
  output logic       o_rready,
  input  logic       i_rreq,
  input  logic [7:0] i_wdata,
  input  logic       i_wvalid,
  output logic       o_wready,
  output logic [7:0] o_mac_tx_data,
  output logic       o_mac_tx_valid,
  output logic       o_mac_tx_last,
  input  logic       i_mac_tx_ready,
  output logic       o_rx_ovf
);

  localparam int RxDepth = 1 << RX_AW;
  localparam int GapW    = $clog2(GAP_CYCLES + 1) + 1;
`ifdef ETH_PORT_TX_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  // ---------------- RX FIFO ----------------
  logic [7:0]     rx_mem [RxDepth];
  logic [RX_AW:0] wr_ptr;
  logic [RX_AW:0] rd_ptr;
  logic           rx_empty;
  logic           rx_full;
  logic           rx_pop;
  logic           rx_push;

  // The frame end is implied by the absence of further data, so the last flag is not used.
  logic unused_rx_last;
  assign unused_rx_last = i_mac_rx_last;

  assign rx_empty = (wr_ptr == rd_ptr);
  assign rx_full  = (wr_ptr[RX_AW-1:0] == rd_ptr[RX_AW-1:0]) &&
                    (wr_ptr[RX_AW] != rd_ptr[RX_AW]);
  assign rx_pop   = i_rreq && !rx_empty;
  // A pop on the same edge frees a slot, so a push is still accepted when the FIFO is full.
  assign rx_push  = i_mac_rx_valid && (!rx_full || rx_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_rx_ovf <= 1'b0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + 1'b1;
      if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (i_mac_rx_valid && !rx_push) o_rx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[wr_ptr[RX_AW-1:0]] <= i_mac_rx_data;
  end

  assign o_rready = !rx_empty;
  assign o_rdata  = rx_empty ? 8'h00 : rx_mem[rd_ptr[RX_AW-1:0]];

  // ---------------- TX framer ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_COLLECT, TX_SEND, TX_PAD} tx_state_t;

  tx_state_t       state;
  logic [10:0]     len;
  logic [10:0]     idx;
  logic [GapW-1:0] gap;
  logic            ready_en;
  logic [7:0]      tx_buf [TX_MAX];
  logic            wr_accept;
  logic            last_stored;
  logic            pad_needed;

  assign o_wready    = ready_en &&
                       ((state == TX_IDLE) ||
                        ((state == TX_COLLECT) && (len < 11'(TX_MAX))));
  assign wr_accept   = i_wvalid && o_wready;
  assign last_stored = (idx == len - 11'd1);
  assign pad_needed  = PadEn && (len < 11'(MIN_LEN));

  assign o_mac_tx_valid = (state == TX_SEND) || (state == TX_PAD);
  assign o_mac_tx_data  = (state == TX_SEND) ? tx_buf[idx] : 8'h00;
  assign o_mac_tx_last  = ((state == TX_SEND) && last_stored && !pad_needed) ||
                          ((state == TX_PAD) && (idx == 11'(MIN_LEN - 1)));

  always_ff @(posedge i_clk) begin
    if (wr_accept) tx_buf[(state == TX_IDLE) ? 11'd0 : len] <= i_wdata;
  end

  // ready_en keeps o_wready low until the first edge after reset is released.
  // Gap timing: the counter reaches GAP_CYCLES, and the next idle edge moves
  // the FSM to TX_SEND. The first valid byte therefore appears GAP_CYCLES+1
  // cycles after the last write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= TX_IDLE;
      len      <= '0;
      idx      <= '0;
      gap      <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        TX_IDLE: begin
          if (wr_accept) begin
            len   <= 11'd1;
            gap   <= '0;
            idx   <= '0;
            state <= TX_COLLECT;
          end
        end
        TX_COLLECT: begin
          if (wr_accept) begin
            len <= len + 11'd1;
            gap <= '0;
          end else if ((len == 11'(TX_MAX)) || (gap == GapW'(GAP_CYCLES))) begin
            idx   <= '0;
            state <= TX_SEND;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        TX_SEND: begin
          if (i_mac_tx_ready) begin
            if (last_stored) begin
              if (pad_needed) begin
                idx   <= idx + 11'd1;
                state <= TX_PAD;
              end else begin
                idx   <= '0;
                len   <= '0;
                state <= TX_IDLE;
              end
            end else begin
              idx <= idx + 11'd1;
            end
          end
        end
        TX_PAD: begin
          if (i_mac_tx_ready) begin
            if (idx == 11'(MIN_LEN - 1)) begin
              idx   <= '0;
              len   <= '0;
              state <= TX_IDLE;
            end else begin
              idx <= idx + 11'd1;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_payload_port.sv
// tb_eth_payload_port
//   Scoreboard bench for eth_payload_port. Expected RX and TX bytes are queued
//   when they are driven, and compared when the DUT presents them.
//   The pad expectations follow ETH_PORT_TX_PAD_EN, which is the same macro
//   that configures the design.
module tb_eth_payload_port;

  localparam int RX_AW      = 10;
  localparam int TX_MAX     = 1500;
  localparam int GAP_CYCLES = 62;
  localparam int MIN_LEN    = 46;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_last = 1'b0;
  logic [7:0] rdata;
  logic       rready;
  logic       rreq = 1'b0;
  logic [7:0] wdata = '0;
  logic       wvalid = 1'b0;
  logic       wready;
  logic [7:0] mac_tx_data;
  logic       mac_tx_valid;
  logic       mac_tx_last;
  logic       mac_tx_ready = 1'b0;
  logic       rx_ovf;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  eth_payload_port #(
    .RX_AW(RX_AW), .TX_MAX(TX_MAX), .GAP_CYCLES(GAP_CYCLES), .MIN_LEN(MIN_LEN)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mac_rx_data(rx_data), .i_mac_rx_valid(rx_valid), .i_mac_rx_last(rx_last),
    .o_rdata(rdata), .o_rready(rready), .i_rreq(rreq),
    .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready),
    .o_mac_tx_data(mac_tx_data), .o_mac_tx_valid(mac_tx_valid),
    .o_mac_tx_last(mac_tx_last), .i_mac_tx_ready(mac_tx_ready),
    .o_rx_ovf(rx_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready got %b want 0", rready); end
    n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL reset_wready got %b want 0", wready); end
    n_cmp++; if (mac_tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_txvalid got %b want 0", mac_tx_valid); end
    n_cmp++; if (mac_tx_last !== 1'b0) begin n_bad++; $display("FAIL reset_txlast got %b want 0", mac_tx_last); end
    n_cmp++; if (mac_tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_txdata got %h want 00", mac_tx_data); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
    n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", rx_ovf); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL release_wready_early got %b want 0", wready); end
    step();
    n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL release_wready got %b want 1", wready); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      rx_data = vals[i]; rx_valid = 1'b1; rx_q.push_back(vals[i]);
      step();
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rready !== 1'b1) begin n_bad++; $display("FAIL rx_basic_rready got %b want 1", rready); end
      n_cmp++; if (rdata !== rx_q[0]) begin n_bad++; $display("FAIL rx_basic_data got %h want %h", rdata, rx_q[0]); end
      void'(rx_q.pop_front());
      rreq = 1'b1; step(); rreq = 1'b0; step();
    end
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL rx_basic_empty got %b want 0", rready); end
    // pop request while empty must be ignored
    rreq = 1'b1; step(); rreq = 1'b0;
    rx_data = 8'h44; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    n_cmp++; if (rdata !== 8'h44 || rready !== 1'b1) begin n_bad++; $display("FAIL rx_empty_pop got %h/%b want 44/1", rdata, rready); end
    rreq = 1'b1; step(); rreq = 1'b0;
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL rx_single_pop got %b want 0", rready); end
  endtask

  task automatic test_rx_overflow();
    int cnt;
    n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_initial got %b want 0", rx_ovf); end
    for (int i = 0; i < (1 << RX_AW); i++) begin
      rx_data = 8'(i) ^ 8'h5A; rx_valid = 1'b1; rx_q.push_back(rx_data);
      step();
    end
    n_cmp++; if (rx_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_at_full got %b want 0", rx_ovf); end
    rx_data = 8'hEE; step();
    rx_valid = 1'b0;
    n_cmp++; if (rx_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", rx_ovf); end
    // simultaneous push and pop while full
    rx_data = 8'h77; rx_valid = 1'b1; rreq = 1'b1;
    n_cmp++; if (rdata !== rx_q[0]) begin n_bad++; $display("FAIL ovf_pushpop_data got %h want %h", rdata, rx_q[0]); end
    void'(rx_q.pop_front()); rx_q.push_back(8'h77);
    step();
    rx_valid = 1'b0; rreq = 1'b0;
    cnt = 0;
    while (rready === 1'b1 && cnt < 1100) begin
      rreq = 1'b1;
      n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL ovf_drain_extra got %h want none", rdata); end
      else begin
        if (rdata !== rx_q[0]) begin n_bad++; $display("FAIL ovf_drain_data got %h want %h", rdata, rx_q[0]); end
        void'(rx_q.pop_front());
      end
      step(); cnt++;
    end
    rreq = 1'b0;
    n_cmp++; if (cnt != (1 << RX_AW)) begin n_bad++; $display("FAIL ovf_occupancy got %0d want %0d", cnt, 1 << RX_AW); end
    n_cmp++; if (rx_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", rx_ovf); end
    rx_q.delete();
  endtask

  task automatic run_tx_frame(input int n, input bit toggle, input logic [7:0] base,
                              input int exp_lat, input string name);
    int k;
    int guard;
    bit tgl;
    tx_q.delete();
    mac_tx_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wdata = base + 8'(i); wvalid = 1'b1;
      n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL %s_wready byte %0d got %b want 1", name, i, wready); end
      tx_q.push_back(wdata);
      step();
    end
    wvalid = 1'b0; wdata = '0;
    n_cmp++;
    if (wready !== (n < TX_MAX)) begin n_bad++; $display("FAIL %s_wready_after got %b want %b", name, wready, n < TX_MAX); end
`ifdef ETH_PORT_TX_PAD_EN
    for (int i = n; i < MIN_LEN; i++) tx_q.push_back(8'h00);
`endif
    k = 0;
    while (mac_tx_valid !== 1'b1 && k < 200) begin step(); k++; end
    n_cmp++; if (k != exp_lat) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", name, k, exp_lat); end
    tgl = 1'b0; guard = 0;
    while (tx_q.size() > 0 && guard < 5000) begin
      mac_tx_ready = toggle ? tgl : 1'b1; tgl = ~tgl;
      n_cmp++;
      if (mac_tx_valid !== 1'b1 || mac_tx_data !== tx_q[0]) begin
        n_bad++; $display("FAIL %s_data got %b/%h want 1/%h", name, mac_tx_valid, mac_tx_data, tx_q[0]);
      end
      n_cmp++;
      if (mac_tx_last !== (tx_q.size() == 1)) begin
        n_bad++; $display("FAIL %s_last got %b want %b", name, mac_tx_last, tx_q.size() == 1);
      end
      if (mac_tx_ready) void'(tx_q.pop_front());
      step(); guard++;
    end
    if (guard >= 5000) begin n_cmp++; n_bad++; $display("FAIL %s_timeout got %0d left want 0", name, tx_q.size()); end
    mac_tx_ready = 1'b0;
    n_cmp++; if (mac_tx_valid !== 1'b0 || wready !== 1'b1) begin
      n_bad++; $display("FAIL %s_idle got valid=%b wready=%b want 0/1", name, mac_tx_valid, wready);
    end
  endtask

  task automatic test_tx_basic();
    run_tx_frame(4, 1'b0, 8'hA0, GAP_CYCLES + 1, "tx_basic");
  endtask

  task automatic test_tx_stall();
    run_tx_frame(4, 1'b1, 8'hA0, GAP_CYCLES + 1, "tx_stall");
  endtask

  task automatic test_tx_pad();
    run_tx_frame(10, 1'b0, 8'hB0, GAP_CYCLES + 1, "tx_pad");
  endtask

  task automatic test_tx_max();
    run_tx_frame(TX_MAX, 1'b0, 8'h00, 1, "tx_max");
  endtask

  task automatic test_reset_mid_tx();
    int k;
    bit saw;
    rx_data = 8'h55; rx_valid = 1'b1; step(); step(); rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wdata = 8'hC0 + 8'(i); wvalid = 1'b1; step();
    end
    wvalid = 1'b0;
    k = 0;
    while (mac_tx_valid !== 1'b1 && k < 200) begin step(); k++; end
    n_cmp++; if (k != GAP_CYCLES + 1) begin n_bad++; $display("FAIL rstmid_latency got %0d want %0d", k, GAP_CYCLES + 1); end
    mac_tx_ready = 1'b1; step();
    n_cmp++; if (mac_tx_data !== 8'hC1) begin n_bad++; $display("FAIL rstmid_byte2 got %h want c1", mac_tx_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mac_tx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", mac_tx_valid); end
    n_cmp++; if (rready !== 1'b0) begin n_bad++; $display("FAIL rstmid_rready got %b want 0", rready); end
    step(); step();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (mac_tx_valid !== 1'b0 || rready !== 1'b0) saw = 1'b1;
    end
    mac_tx_ready = 1'b0;
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL rstmid_residue got %b want 0", saw); end
    n_cmp++; if (wready !== 1'b1) begin n_bad++; $display("FAIL rstmid_wready got %b want 1", wready); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_overflow();
    test_tx_basic();
    test_tx_stall();
    test_tx_pad();
    test_tx_max();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_payload_port.md
ETH_PAYLOAD_PORT -- requirements
Module: eth_payload_port

Interface
REQ-001 Parameter RX_AW, default 10, RX FIFO address width (depth 2**RX_AW bytes).
REQ-002 Parameter TX_MAX, default 1500, maximum TX frame length in bytes.
REQ-003 Parameter GAP_CYCLES, default 62, idle cycles after the last accepted write byte that close a TX frame.
REQ-004 Parameter MIN_LEN, default 46, minimum TX frame length when padding is compiled in.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. Ports i_clk (in, 1, rising-edge clock) and i_rst_n (in, 1, asynchronous active-low reset).
REQ-006 Ports i_mac_rx_data (in, 8, RX byte), i_mac_rx_valid (in, 1, RX byte strobe), i_mac_rx_last (in, 1, last RX byte of frame).
REQ-007 Ports o_rdata (out, 8, head-of-FIFO byte), o_rready (out, 1, FIFO not empty), i_rreq (in, 1, pop request).
REQ-008 Ports i_wdata (in, 8, TX byte), i_wvalid (in, 1, TX byte strobe), o_wready (out, 1, TX byte accepted when high).
REQ-009 Ports o_mac_tx_data (out, 8), o_mac_tx_valid (out, 1), o_mac_tx_last (out, 1), i_mac_tx_ready (in, 1): TX frame stream to MAC.
REQ-010 Port o_rx_ovf (out, 1): sticky RX overflow flag.

Function
REQ-011 RX FIFO shall be show-ahead: o_rdata equals the head byte whenever o_rready=1, with no read latency.
REQ-012 Pop occurs on the rising edge where i_rreq=1 and o_rready=1; i_rreq while empty shall be ignored.
REQ-013 A byte is pushed on every edge with i_mac_rx_valid=1 and FIFO not full; i_mac_rx_last carries no FIFO side effect (frame end signalled downstream by absence of data).
REQ-014 Push while full shall drop the byte and set o_rx_ovf; FIFO contents unchanged.
REQ-015 Simultaneous push and pop: both occur, occupancy unchanged; allowed at full (pop frees slot same edge, push accepted) and at empty only the push occurs.
REQ-016 Pointers RX_AW+1 bits wide, wrap modulo 2**(RX_AW+1); full when addresses equal and MSBs differ.
REQ-017 TX FSM states TX_IDLE, TX_COLLECT, TX_SEND, TX_PAD.
REQ-018 TX_IDLE: o_wready=1; accepted byte stored at index 0, length=1, gap counter cleared, go TX_COLLECT.
REQ-019 TX_COLLECT: o_wready=1 while length<TX_MAX; each accepted byte appended and gap counter cleared; otherwise gap counter increments.
REQ-020 TX_COLLECT -> TX_SEND when gap counter reaches GAP_CYCLES or length reaches TX_MAX, whichever first.
REQ-021 TX_SEND/TX_PAD: o_wready=0; o_mac_tx_valid=1; byte index advances on edges where i_mac_tx_ready=1; o_mac_tx_data stable while i_mac_tx_ready=0.
REQ-022 o_mac_tx_last=1 exactly on the final byte (final stored byte, or final pad byte); after its acceptance FSM returns to TX_IDLE next cycle with o_mac_tx_valid=0.
REQ-023 Length counter 11 bits; TX buffer TX_MAX bytes, index wraps never (bounded by REQ-019).
REQ-024 Latency: first o_mac_tx_valid asserted GAP_CYCLES+1 cycles after the last accepted write byte.

Reset
REQ-025 Reset asynchronously clears FIFO pointers, o_rx_ovf, TX FSM to TX_IDLE, length and gap counters, independent of i_clk.
REQ-026 Reset values: o_rready=0, o_wready=0 during reset then 1 from first edge after deassertion, o_mac_tx_valid=0, o_mac_tx_last=0, o_mac_tx_data=0, o_rdata=0 when empty.
REQ-027 Reset mid-frame (RX or TX) discards the partial frame; no byte of it is emitted after deassertion.

Configuration
REQ-028 Macro ETH_PORT_TX_PAD_EN: when defined, frames shorter than MIN_LEN enter TX_PAD after the stored bytes and emit 8'h00 until MIN_LEN bytes are sent; when undefined, TX_PAD is unreachable and frames are sent at stored length.

Verification
REQ-029 Push 3 RX bytes 0x11,0x22,0x33, pulse i_rreq one cycle each -> o_rdata reads 0x11,0x22,0x33, o_rready drops after third pop.
REQ-030 Fill RX FIFO to 1024, push one more -> byte dropped, o_rx_ovf=1; simultaneous push+pop at full -> occupancy stays 1024.
REQ-031 Write 4 bytes 0xA0..0xA3, hold i_mac_tx_ready=1 -> first o_mac_tx_valid 63 cycles after last write, 4 bytes, o_mac_tx_last on 0xA3.
REQ-032 Same with i_mac_tx_ready toggling every cycle -> identical byte sequence, data stable during stall.
REQ-033 ETH_PORT_TX_PAD_EN defined, write 10 bytes -> 46 bytes emitted, bytes 11..46 = 0x00, last on byte 46; undefined -> 10 bytes.
REQ-034 Assert i_rst_n=0 during TX_SEND byte 2 -> o_mac_tx_valid low immediately, no further bytes after release.
